// File: rtl/dma_bus_arbiter.sv
// Memory bus arbiter with an OAM DMA engine: the CPU passes straight through
// when idle; during a transfer only HRAM and DMA-register accesses reach memory.
module dma_bus_arbiter #(
  parameter int unsigned DMA_LEN  = 160,
  parameter logic [15:0] OAM_BASE = 16'hFE00,
  parameter logic [15:0] DMA_REG  = 16'hFF46,
  parameter logic [15:0] HRAM_LO  = 16'hFF80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output logic        dma_done
);
  localparam logic [7:0]  LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [15:0] HRAM_HI  = 16'hFFFE;

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

  state_t     state, state_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] src_hi, src_hi_nxt;
  logic [7:0] dbuf, dbuf_nxt;
  logic       done_nxt;
  logic       cpu_acc, hram_hit, reg_wr;

  // Source pages E0..FF alias the work RAM echo region, so fold them down.
  function automatic logic [7:0] echo_map(input logic [7:0] v);
    return (v >= 8'hE0) ? (v - 8'h20) : v;
  endfunction

  assign cpu_acc    = cpu_re | cpu_we;
  assign hram_hit   = cpu_acc && (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
  assign reg_wr     = cpu_we && (cpu_addr == DMA_REG);
  assign dma_active = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= 8'h00;
      src_hi   <= 8'h00;
      dbuf     <= 8'h00;
      dma_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      src_hi   <= src_hi_nxt;
      dbuf     <= dbuf_nxt;
      dma_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    src_hi_nxt = src_hi;
    dbuf_nxt   = dbuf;
    done_nxt   = 1'b0;
    mem_addr   = cpu_addr;
    mem_re     = cpu_re & ~cpu_we;
    mem_we     = cpu_we;
    mem_wdata  = cpu_wdata;
    cpu_rdata  = mem_rdata;

    if (reg_wr) begin
      // A DMA register write always reaches memory and (re)starts the copy.
      src_hi_nxt = echo_map(cpu_wdata);
      idx_nxt    = 8'h00;
      state_nxt  = START;
    end else if ((state != IDLE) && !hram_hit) begin
      // DMA owns the bus; a CPU HRAM access would instead stall the engine.
      cpu_rdata = 8'hFF;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      case (state)
        START: state_nxt = READ;
        READ: begin
          mem_addr  = {src_hi, idx};
          mem_re    = 1'b1;
          dbuf_nxt  = mem_rdata;
          state_nxt = WRITE;
        end
        WRITE: begin
          mem_addr  = OAM_BASE + {8'h00, idx};
          mem_we    = 1'b1;
          mem_wdata = dbuf;
          if (idx == LAST_IDX) begin
            idx_nxt   = 8'h00;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt   = idx + 8'h01;
            state_nxt = READ;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Owns the single 8-bit memory bus between the datapath (CPU) and the memoryunit.
- Contains the OAM DMA engine: a CPU write to the DMA register starts a copy of DMA_LEN bytes from {src_hi,8'h00} to OAM_BASE.
- While DMA runs, the block arbitrates the bus. CPU accesses to HRAM win. All other CPU accesses are blocked.
- Sits between dp and mu in top. The top-level tri-state memd adaptation stays outside this block.

Parameters:
- DMA_LEN, 160, number of bytes copied per transfer.
- OAM_BASE, 16'hFE00, destination base address.
- DMA_REG, 16'hFF46, address of the DMA start/source register.
- HRAM_LO, 16'hFF80, lowest HRAM address; HRAM spans HRAM_LO..16'hFFFE.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  CPU address (MAR).
- cpu_re  in  1  CPU read enable.
- cpu_we  in  1  CPU write enable.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  read data returned to CPU (combinational).
- mem_addr  out  16  address to memoryunit.
- mem_re  out  1  read enable to memoryunit.
- mem_we  out  1  write enable to memoryunit.
- mem_wdata  out  8  write data to memoryunit.
- mem_rdata  in  8  memoryunit read data, valid in the same cycle as mem_re (combinational read).
- dma_active  out  1  high from the START state through the last WRITE.
- dma_done  out  1  one-cycle pulse in the cycle after the final byte is written.

Behaviour:
- Reset (rst=0, async):
  - State=IDLE; idx=0; src_hi=8'h00; dbuf=8'h00.
  - dma_active=0; dma_done=0.
  - Bus outputs follow the IDLE mux: CPU inputs pass through.
- States: IDLE, START, READ, WRITE.
- IDLE:
  - mem_* = cpu_* pass-through; cpu_rdata = mem_rdata.
  - cpu_we with cpu_addr==DMA_REG is forwarded to memory (register reads back).
  - On that write, capture src_hi = cpu_wdata, or cpu_wdata-8'h20 if cpu_wdata>=8'hE0 (echo map).
  - Then go to START with idx=0.
- START: one dead cycle, no DMA bus activity. CPU is already blocked. dma_active=1. Next state is READ.
- READ:
  - mem_addr={src_hi,idx}, mem_re=1, mem_we=0.
  - dbuf<=mem_rdata at the closing edge. Next state is WRITE.
- WRITE:
  - mem_addr=OAM_BASE+idx, mem_we=1, mem_wdata=dbuf.
  - idx<=idx+1.
  - If idx==DMA_LEN-1: go to IDLE and pulse dma_done next cycle. Otherwise go to READ.
- Throughput: 2 cycles per byte. Total is 1+2*DMA_LEN = 321 cycles from the DMA_REG write edge to dma_done.
- CPU arbitration while dma_active:
  - CPU access with cpu_addr in HRAM_LO..FFFE: CPU gets the bus that cycle (pass-through). DMA holds its state, idx and dbuf (stall cycle, no advance).
  - Other CPU reads return cpu_rdata=8'hFF and are not issued to memory.
  - Other CPU writes are dropped, except DMA_REG.
  - CPU write to DMA_REG during DMA: forwarded to memory, captures a new src_hi, sets idx=0, goes to START. This is a restart; any in-flight byte is abandoned. No dma_done for the aborted transfer.
- Simultaneous events:
  - CPU re and we asserted together: treated as a write.
  - HRAM access during START: also stalls START.
- Widths:
  - idx is 8 bits and never exceeds DMA_LEN-1.
  - OAM_BASE+idx is a 16-bit add with no wrap.
  - src_hi with idx gives {src_hi,idx}.
- Reset mid-transfer: immediate return to IDLE. The partially written OAM is left as-is. No dma_done.

Test Plan:
- Reset, then CPU write 8'hC0 to FF46. Expect dma_active=1 next cycle. Expect reads C000..C09F and writes FE00..FE9F, byte-identical to a preloaded pattern. Expect dma_done pulse exactly 321 cycles after the write, then dma_active=0.
- During DMA, CPU reads 16'h8000 -> cpu_rdata=8'hFF, no mem_re at 8000. CPU writes 16'hC100 -> no mem_we, memory unchanged.
- During DMA, CPU reads FF90 for 3 cycles -> data returned correctly. DMA idx frozen for those 3 cycles. Total duration 324 cycles. OAM contents still correct.
- Mid-transfer (idx=50), CPU writes 8'hD0 to FF46 -> idx restarts at 0 with source D000. Final OAM equals D000..D09F. Exactly one dma_done.
- Write 8'hE3 to FF46 -> source reads come from C300..C39F.
- Assert rst low during a WRITE state -> all outputs at reset values asynchronously. The next FF46 write starts a clean transfer.
